// File: rtl/systol_mm_engine_if.sv
// Memory/handshake bundle for systol_mm_engine: run request, finish flag,
// synchronous read port and write port towards the shared data RAM.
interface systol_mm_engine_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 8,
  parameter int ADDR_W = 14
);
  logic              start;
  logic              finish;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W-1:0] read_select;
  logic [ADDR_W-1:0] ws;
  logic [RES_W-1:0]  result;
  logic              we;

  modport master (
    input  start, read_data,
    output finish, read_select, ws, result, we
  );

  modport slave (
    output start, read_data,
    input  finish, read_select, ws, result, we
  );
endinterface

// File: rtl/systol_mm_engine.sv
// N x N systolic matrix multiplier: loads A and B from memory, multiplies, writes C back.
// Optional macro SYSTOL_SATURATE_EN clamps written results instead of truncating them.
module systol_mm_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 8,
  parameter int ADDR_W = 14,
  parameter int A_BASE = 0,
  parameter int B_BASE = N * N,
  parameter int C_BASE = 2 * N * N
) (
  input logic clk,
  input logic rst,
  systol_mm_engine_if.master bus
);
  localparam int NN        = N * N;
  localparam int TOTAL     = 2 * NN;
  localparam int ACC_W     = 2 * DATA_W + $clog2(N);
  localparam int LD_W      = $clog2(TOTAL + 1);
  localparam int WR_W      = $clog2(NN + 1);
  localparam int STEP_W    = $clog2(3 * N - 2);
  localparam int LAST_STEP = 3 * N - 3;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

  state_t              state;
  logic [LD_W-1:0]     ld_cnt;
  logic [LD_W-1:0]     cap_idx;
  logic                cap_valid;
  logic [STEP_W-1:0]   step;
  logic [WR_W-1:0]     wr_cnt;
  logic [DATA_W-1:0]   a_file [NN];
  logic [DATA_W-1:0]   b_file [NN];
  logic [DATA_W-1:0]   a_pipe [NN];
  logic [DATA_W-1:0]   b_pipe [NN];
  logic [DATA_W-1:0]   cell_a [NN];
  logic [DATA_W-1:0]   cell_b [NN];
  logic [ACC_W-1:0]    acc    [NN];
  logic [DATA_W-1:0]   feed_a [N];
  logic [DATA_W-1:0]   feed_b [N];
  logic [ACC_W-1:0]    sel_acc;
  logic                load_done;

  assign load_done = (state == LOAD) && cap_valid && (cap_idx == LD_W'(TOTAL - 1));

  function automatic logic [ADDR_W-1:0] load_addr(input logic [LD_W-1:0] idx);
    if (idx < LD_W'(NN)) return ADDR_W'(A_BASE) + ADDR_W'(idx);
    return ADDR_W'(B_BASE) + ADDR_W'(idx - LD_W'(NN));
  endfunction

  function automatic logic [RES_W-1:0] to_result(input logic [ACC_W-1:0] value);
`ifdef SYSTOL_SATURATE_EN
    if (RES_W >= ACC_W) return RES_W'(value);
    if ((value >> RES_W) != '0) return '1;
    return RES_W'(value);
`else
    return RES_W'(value);
`endif
  endfunction

  // Skewed edge feeds: row i of A and column i of B are delayed by i steps.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_b[i] = '0;
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (step == STEP_W'(i + k)) begin
          feed_a[i] = a_file[i * N + k];
          feed_b[i] = b_file[k * N + i];
        end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cell_a[i * N] = feed_a[i];
      cell_b[i]     = feed_b[i];
      for (int j = 1; j < N; j++) begin
        cell_a[i * N + j] = a_pipe[i * N + j - 1];
        cell_b[j * N + i] = b_pipe[(j - 1) * N + i];
      end
    end
  end

  always_comb begin
    sel_acc = '0;
    for (int e = 0; e < NN; e++)
      if (wr_cnt == WR_W'(e)) sel_acc = acc[e];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NN; e++) begin
        a_file[e] <= '0;
        b_file[e] <= '0;
      end
    end else if (state == LOAD && cap_valid) begin
      for (int e = 0; e < NN; e++) begin
        if (cap_idx == LD_W'(e))      a_file[e] <= bus.read_data;
        if (cap_idx == LD_W'(e + NN)) b_file[e] <= bus.read_data;
      end
    end
  end

  // MAC array: accumulators and forwarding registers cleared as COMPUTE is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NN; e++) begin
        acc[e]    <= '0;
        a_pipe[e] <= '0;
        b_pipe[e] <= '0;
      end
    end else if (load_done) begin
      for (int e = 0; e < NN; e++) begin
        acc[e]    <= '0;
        a_pipe[e] <= '0;
        b_pipe[e] <= '0;
      end
    end else if (state == COMPUTE) begin
      for (int e = 0; e < NN; e++) begin
        acc[e]    <= acc[e] + ACC_W'(cell_a[e]) * ACC_W'(cell_b[e]);
        a_pipe[e] <= cell_a[e];
        b_pipe[e] <= cell_b[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      ld_cnt          <= '0;
      cap_idx         <= '0;
      cap_valid       <= 1'b0;
      step            <= '0;
      wr_cnt          <= '0;
      bus.read_select <= '0;
      bus.ws          <= '0;
      bus.result      <= '0;
      bus.we          <= 1'b0;
      bus.finish      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.we     <= 1'b0;
          bus.finish <= 1'b0;
          if (bus.start) begin
            state           <= LOAD;
            ld_cnt          <= '0;
            cap_valid       <= 1'b0;
            bus.read_select <= ADDR_W'(A_BASE);
          end
        end
        LOAD: begin
          // cap_idx trails the presented address by the one-cycle RAM latency.
          if (ld_cnt < LD_W'(TOTAL)) begin
            cap_valid <= 1'b1;
            cap_idx   <= ld_cnt;
            ld_cnt    <= ld_cnt + 1'b1;
            if (ld_cnt < LD_W'(TOTAL - 1)) bus.read_select <= load_addr(ld_cnt + 1'b1);
          end else begin
            cap_valid <= 1'b0;
          end
          if (load_done) begin
            state <= COMPUTE;
            step  <= '0;
          end
        end
        COMPUTE: begin
          if (step == STEP_W'(LAST_STEP)) begin
            state  <= WRITE;
            wr_cnt <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        WRITE: begin
          if (wr_cnt == WR_W'(NN)) begin
            bus.we     <= 1'b0;
            bus.finish <= 1'b1;
            state      <= DONE;
          end else begin
            bus.we     <= 1'b1;
            bus.ws     <= ADDR_W'(C_BASE) + ADDR_W'(wr_cnt);
            bus.result <= to_result(sel_acc);
            wr_cnt     <= wr_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state      <= IDLE;
            bus.finish <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systol_mm_engine.sv
// Directed bench for systol_mm_engine: N=4/8-bit instance plus an N=2/16-bit/32-bit variant.
// Cycle k below means "just after the k-th rising edge", edge 0 being the one that samples start.
module tb_systol_mm_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systol_mm_engine_if #(.DATA_W(8),  .RES_W(8),  .ADDR_W(14)) bus0 ();
  systol_mm_engine_if #(.DATA_W(16), .RES_W(32), .ADDR_W(14)) bus1 ();

  systol_mm_engine #(.N(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  systol_mm_engine #(.N(2), .DATA_W(16), .RES_W(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0]  mem0 [64];
  logic [15:0] mem1 [16];

  always @(posedge clk) begin
    bus0.read_data <= mem0[bus0.read_select[5:0]];
    bus1.read_data <= mem1[bus1.read_select[3:0]];
  end

  int     checks = 0;
  int     fails  = 0;
  longint wr_a [64];
  longint wr_d [64];
  longint exp_c [16];
  int     nw, first_we, last_we, fin_cyc;
  int     extra_we, fin_low;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic recordWrite(input int k, input longint addr, input longint data);
    if (nw < 64) begin
      wr_a[nw] = addr;
      wr_d[nw] = data;
    end
    nw++;
    if (first_we < 0) first_we = k;
    last_we = k;
  endtask

  // Raises start, then watches one run cycle by cycle until finish (bounded).
  task automatic applyStimulus(input int sel, input int drop_cyc, input int pulse_cyc);
    nw = 0; first_we = -1; last_we = -1; fin_cyc = -1;
    if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        if (k == 16) checkOutput("rs_b_base", bus0.read_select, 16);
        if (k == 31) checkOutput("rs_last", bus0.read_select, 31);
        if (k == 40) checkOutput("rs_hold", bus0.read_select, 31);
        if (bus0.we) recordWrite(k, bus0.ws, bus0.result);
        if (bus0.finish) begin
          fin_cyc = k;
          break;
        end
      end else begin
        if (bus1.we) recordWrite(k, bus1.ws, bus1.result);
        if (bus1.finish) begin
          fin_cyc = k;
          break;
        end
      end
      if (k == drop_cyc || (pulse_cyc >= 0 && k == pulse_cyc + 1)) begin
        if (sel == 0) bus0.start = 1'b0; else bus1.start = 1'b0;
      end
      if (k == pulse_cyc) begin
        if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
      end
    end
    if (fin_cyc < 0) checkOutput("run_timeout", 0, 1);
  endtask

  task automatic checkRun(input string tag, input int nexp, input int base,
                          input int exp_first, input int exp_fin);
    checkOutput({tag, "_nwrites"}, nw, nexp);
    checkOutput({tag, "_first_we"}, first_we, exp_first);
    checkOutput({tag, "_last_we"}, last_we, exp_first + nexp - 1);
    checkOutput({tag, "_finish_cyc"}, fin_cyc, exp_fin);
    for (int k = 0; k < nexp && k < nw; k++) begin
      checkOutput({tag, "_addr"}, wr_a[k], base + k);
      checkOutput({tag, "_data"}, wr_d[k], exp_c[k]);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_read_select"}, bus0.read_select, 0);
    checkOutput({tag, "_ws"}, bus0.ws, 0);
    checkOutput({tag, "_result"}, bus0.result, 0);
    checkOutput({tag, "_we"}, bus0.we, 0);
    checkOutput({tag, "_finish"}, bus0.finish, 0);
  endtask

  task automatic loadIdentity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mem0[i * 4 + j]      = (i == j) ? 8'd1 : 8'd0;
        mem0[16 + i * 4 + j] = 8'(4 * i + j + 1);
        exp_c[i * 4 + j]     = 4 * i + j + 1;
      end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int e = 0; e < 64; e++) mem0[e] = 8'd1;
    for (int e = 0; e < 16; e++) mem1[e] = 16'd1000;
    repeat (3) @(negedge clk);
    checkCleared("reset");
    rst = 1'b1;
    @(negedge clk);

    // All-ones run with start held high throughout.
    for (int e = 0; e < 16; e++) exp_c[e] = 4;
    applyStimulus(0, -1, -1);
    checkRun("ones", 16, 32, 44, 60);
    extra_we = 0; fin_low = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus0.we) extra_we++;
      if (!bus0.finish) fin_low++;
    end
    checkOutput("held_no_rerun", extra_we, 0);
    checkOutput("held_finish_low_cycles", fin_low, 0);

    bus0.start = 1'b0;
    @(negedge clk);
    checkOutput("finish_fall", bus0.finish, 0);
    applyStimulus(0, -1, -1);
    checkRun("rerun", 16, 32, 44, 60);
    bus0.start = 1'b0;
    @(negedge clk);

    // Identity A with a stray start pulse during WRITE at cycle 50.
    loadIdentity();
    applyStimulus(0, 2, 50);
    checkRun("ident", 16, 32, 44, 60);
    extra_we = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.we) extra_we++;
    end
    checkOutput("pulse_no_extra_writes", extra_we, 0);
    checkOutput("pulse_finish_low", bus0.finish, 0);

    // 255 * 255 * 4 = 260100 overflows an 8-bit result.
    for (int e = 0; e < 64; e++) mem0[e] = 8'd255;
`ifdef SYSTOL_SATURATE_EN
    for (int e = 0; e < 16; e++) exp_c[e] = 255;
`else
    for (int e = 0; e < 16; e++) exp_c[e] = 4;
`endif
    applyStimulus(0, 3, -1);
    checkRun("ovf", 16, 32, 44, 60);
    @(negedge clk);

    // Reset asserted mid-LOAD, then a fresh run.
    loadIdentity();
    bus0.start = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_rs", bus0.read_select, 9);
    rst = 1'b0;
    bus0.start = 1'b0;
    #1;
    checkCleared("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_idle_rs", bus0.read_select, 0);
    applyStimulus(0, -1, -1);
    checkRun("after_reset", 16, 32, 44, 60);
    bus0.start = 1'b0;
    @(negedge clk);

    // Width variant: 1000 * 1000 * 2 = 2000000.
    for (int e = 0; e < 4; e++) exp_c[e] = 2000000;
    applyStimulus(1, -1, -1);
    checkRun("wide", 4, 8, 14, 18);
    bus1.start = 1'b0;
    @(negedge clk);
    checkOutput("wide_finish_fall", bus1.finish, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
